uart_tx_buffer: RTL

// - Byte FIFO plus launch controller sitting directly upstream of the UART transmitter.
// - Accepts bytes from a host at clk rate, holds up to DEPTH of them, and feeds them one at a time to the transmitter.
// - Transmitter interface: a tx_start/tx_data pulse per byte; the next byte is launched only after the transmitter pulses tx_done.
// - Optional watchdog recovers if tx_done never arrives.

---
 rtl/uart_tx_buffer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: byte FIFO feeding a UART transmitter one frame at a time.
// A byte is popped in IDLE, announced with a one-cycle tx_start in LAUNCH,
// and held on tx_data through WAIT until tx_done (or the optional watchdog).
module uart_tx_buffer #(
  parameter int DEPTH        = 16,
  parameter int ADDR_W       = 4,
  parameter int DONE_TIMEOUT = 0,
  parameter int TMO_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  input  logic              err_clr,
  input  logic              tx_done,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              overflow,
  output logic              timeout_err
);

  localparam int CW = ADDR_W + 1;
  localparam bit WDT_EN = (DONE_TIMEOUT > 0);
  // Counter value seen during the last permitted WAIT cycle.
  localparam int TMO_LAST_I = WDT_EN ? DONE_TIMEOUT - 1 : 0;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_LAST_I[TMO_W-1:0];

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              ovf_q, ovf_d;
  logic              tmo_err_q, tmo_err_d;
  logic              push, drop, pop, abort;

  // Flags are decoded from the registered count only, so a same-cycle pop
  // never makes room for a write.
  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign tx_start = (state_q == S_LAUNCH);
  assign busy     = (state_q != S_IDLE);
  assign tx_data  = tx_data_q;
  assign overflow    = ovf_q;
  assign timeout_err = tmo_err_q;

  assign push = wr_en && !full;
  assign drop = wr_en && full;

  // Launch FSM: next state, pop decision and watchdog count.
  always_comb begin
    state_d   = state_q;
    rd_ptr_d  = rd_ptr_q;
    tx_data_d = tx_data_q;
    tmo_d     = '0;
    pop       = 1'b0;
    abort     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop       = 1'b1;
          tx_data_d = mem_q[rd_ptr_q];
          rd_ptr_d  = rd_ptr_q + ADDR_W'(1);
          state_d   = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        // tx_done here belongs to nothing we launched; ignore it.
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (tx_done) begin
          state_d = S_IDLE;
        end else if (WDT_EN && (tmo_q == TMO_LAST)) begin
          abort   = 1'b1;
          state_d = S_IDLE;
        end else if (WDT_EN) begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO bookkeeping and sticky error flags (set beats clear).
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    ovf_d = ovf_q;
    if (drop)         ovf_d = 1'b1;
    else if (err_clr) ovf_d = 1'b0;
    tmo_err_d = tmo_err_q;
    if (abort)        tmo_err_d = 1'b1;
    else if (err_clr) tmo_err_d = 1'b0;
  end

  // Control state; everything here is cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      tx_data_q <= '0;
      tmo_q     <= '0;
      ovf_q     <= 1'b0;
      tmo_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      tx_data_q <= tx_data_d;
      tmo_q     <= tmo_d;
      ovf_q     <= ovf_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  // Storage array; no reset, stale bytes are unreachable once count is 0.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule
